rpn_stack_ctrl: RTL and testbench
=================================

// Module: rpn_stack_ctrl
// PURPOSE
//  Initiator side of the 8x4 LIFO stack interface: a reverse-Polish evaluator FSM that drives
//  push/pop strobes into the stack and consumes its registered data_out. Accepts a stream of
//  tokens (4-bit operands or opcodes), evaluates them, and leaves each result on top of stack.
//  Sits between the keypad/switch token front-end and the stack block; both share clk/rstN.
// PARAMETERS
//  WIDTH    4  data width of operands, results and stack entries
//  DEPTH    8  stack depth; must match the attached stack instance
//  DEPTH_W  4  width of internal depth counter (holds 0..DEPTH)
// PORTS
//  clk          in   1      single clock, all state on posedge
//  rstN         in   1      asynchronous, active-low reset
//  tok_valid    in   1      token present; consumed on a cycle where tok_valid && tok_ready
//  tok_is_op    in   1      1 = tok_data is an opcode, 0 = operand
//  tok_data     in   WIDTH  operand value or opcode
//  tok_ready    out  1      controller idle and able to accept a token
//  stk_data_in  out  WIDTH  value to push
//  stk_push     out  1      one-cycle push strobe
//  stk_pop      out  1      one-cycle pop strobe (never asserted together with stk_push)
//  stk_data_out in   WIDTH  stack registered output; valid the cycle after a pop strobe
//  stk_full     in   1      stack full flag
//  stk_empty    in   1      stack empty flag
//  result       out  WIDTH  last computed result, held until next op completes
//  result_valid out  1      one-cycle pulse when result updates
//  error        out  1      sticky error flag
// BEHAVIOUR
//  Reset (async, rstN=0): state IDLE, depth=0, all outputs 0 except tok_ready=0 during reset,
//   tok_ready=1 from first clock after release. Mid-operation reset aborts with no strobes.
//  States: IDLE, PUSH_NUM, POP_B, CAP_B, POP_A, CAP_A, PUSH_RES, ERR.
//  IDLE: tok_ready=1. Operand token -> PUSH_NUM if depth<DEPTH && !stk_full, else ERR.
//   Opcode token -> POP_B if depth>=2 and opcode legal, else ERR (stack left untouched).
//  PUSH_NUM: stk_push=1, stk_data_in=operand, depth+1 -> IDLE. Operand latency: accept N, push N+1.
//  POP_B: stk_pop=1 -> CAP_B: b<=stk_data_out -> POP_A: stk_pop=1 -> CAP_A: a<=stk_data_out
//   -> PUSH_RES: stk_push=1, stk_data_in=f(a,b), result<=f(a,b), result_valid=1, depth-1 -> IDLE.
//   Opcode accepted cycle N: pops at N+1,N+3; push+result_valid at N+5; tok_ready again N+6.
//  Opcodes: 0 ADD a+b, 1 SUB a-b, 2 AND, 3 OR, 4 XOR; codes 5..15 illegal -> ERR.
//   a = older (deeper) operand, b = top. Arithmetic modulo 2^WIDTH, carry/borrow discarded.
//  ERR: error=1, tok_ready=0, no strobes; exits only via rstN.
//  Depth tracked internally (not from stk_empty) so underflow is detected before any pop.
//  Strobes are exactly one cycle; tokens presented while tok_ready=0 are ignored, not queued.
// STRUCTURE
//  Package rpn_pkg: state enum, opcode localparams (OP_ADD..OP_XOR), WIDTH/DEPTH defaults.
//  Sub-module rpn_alu: combinational f(op,a,b) -> WIDTH result; FSM + counter in top.
// TESTING (bench instantiates rpn_stack_ctrl + stack, shared clk/rstN)
//  Push 3, 4, op ADD -> result=7, result_valid pulse 5 cycles after op accept, stack depth 1.
//  Push 2, 5, op SUB -> result=13 (2-5 mod 16); push 9, 9, op ADD -> result=2 (18 mod 16).
//  Push 8 operands then 9th operand -> error=1, tok_ready=0, no 9th push strobe seen.
//  Push 1 operand then op AND -> error=1, zero pop strobes issued.
//  Opcode 7 with depth 2 -> error=1, stack contents intact; rstN pulse clears error, depth=0.
//  Assert rstN=0 at POP_A of an op -> all strobes 0 immediately, tok_ready=1 after release.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN evaluator: size defaults, opcode encodings
// and the controller state type.
package rpn_pkg;

  localparam int unsigned RPN_WIDTH   = 4;
  localparam int unsigned RPN_DEPTH   = 8;
  localparam int unsigned RPN_DEPTH_W = 4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PUSH_NUM = 3'd1,
    POP_B    = 3'd2,
    CAP_B    = 3'd3,
    POP_A    = 3'd4,
    CAP_A    = 3'd5,
    PUSH_RES = 3'd6,
    ERR      = 3'd7
  } rpn_state_e;

endpackage

// File: rtl/rpn_stack_ctrl_if.sv
// Token stream and LIFO stack signals seen by the RPN controller.
// master = controller side, slave = token source plus stack side.
interface rpn_stack_ctrl_if #(
  parameter int unsigned WIDTH = rpn_pkg::RPN_WIDTH
);
  logic             tok_valid;
  logic             tok_is_op;
  logic [WIDTH-1:0] tok_data;
  logic             tok_ready;
  logic [WIDTH-1:0] stk_data_in;
  logic             stk_push;
  logic             stk_pop;
  logic [WIDTH-1:0] stk_data_out;
  logic             stk_full;
  logic             stk_empty;

  modport master (
    input  tok_valid, tok_is_op, tok_data, stk_data_out, stk_full, stk_empty,
    output tok_ready, stk_data_in, stk_push, stk_pop
  );

  modport slave (
    output tok_valid, tok_is_op, tok_data, stk_data_out, stk_full, stk_empty,
    input  tok_ready, stk_data_in, stk_push, stk_pop
  );
endinterface

// File: rtl/rpn_alu.sv
// Combinational operator for the RPN evaluator; a is the deeper operand,
// b the top of stack. Results wrap modulo 2^WIDTH.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = RPN_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rpn_stack_ctrl.sv
// Reverse-Polish evaluator FSM driving push/pop strobes into an external
// LIFO; tracks stack depth itself so underflow is caught before any pop.
module rpn_stack_ctrl
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH   = RPN_WIDTH,
  parameter int unsigned DEPTH   = RPN_DEPTH,
  parameter int unsigned DEPTH_W = RPN_DEPTH_W
) (
  input  logic             clk,
  input  logic             rstN,
  rpn_stack_ctrl_if.master bus,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             error
);

  rpn_state_e         state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               rv_q, rv_d;
  logic               live_q;
  logic [WIDTH-1:0]   alu_y;
  logic               tok_ready_w;
  logic               tok_fire;
  logic               op_legal;

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .op (op_q),
    .a  (bus.stk_data_out),
    .b  (b_q),
    .y  (alu_y)
  );

  // live_q keeps tok_ready low while reset is held and for no longer
  assign tok_ready_w = live_q && (state_q == IDLE);
  assign tok_fire    = bus.tok_valid && tok_ready_w;
  assign op_legal    = (bus.tok_data <= WIDTH'(OP_XOR));

  always_comb begin
    state_d  = state_q;
    depth_d  = depth_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    b_d      = b_q;
    result_d = result_q;
    rv_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (tok_fire) begin
          if (!bus.tok_is_op) begin
            if ((depth_q < DEPTH_W'(DEPTH)) && !bus.stk_full) begin
              opnd_d  = bus.tok_data;
              state_d = PUSH_NUM;
            end else begin
              state_d = ERR;
            end
          end else if ((depth_q >= DEPTH_W'(2)) && !bus.stk_empty && op_legal) begin
            op_d    = bus.tok_data[2:0];
            state_d = POP_B;
          end else begin
            state_d = ERR;
          end
        end
      end
      PUSH_NUM: begin
        depth_d = depth_q + DEPTH_W'(1);
        state_d = IDLE;
      end
      POP_B: state_d = CAP_B;
      CAP_B: begin
        b_d     = bus.stk_data_out;
        state_d = POP_A;
      end
      POP_A: state_d = CAP_A;
      // Result is computed as a arrives so it is registered during PUSH_RES.
      CAP_A: begin
        result_d = alu_y;
        rv_d     = 1'b1;
        state_d  = PUSH_RES;
      end
      PUSH_RES: begin
        depth_d = depth_q - DEPTH_W'(1);
        state_d = IDLE;
      end
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= IDLE;
      depth_q  <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      b_q      <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      depth_q  <= depth_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      b_q      <= b_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      live_q   <= 1'b1;
    end
  end

  assign bus.tok_ready   = tok_ready_w;
  assign bus.stk_push    = (state_q == PUSH_NUM) || (state_q == PUSH_RES);
  assign bus.stk_pop     = (state_q == POP_B) || (state_q == POP_A);
  assign bus.stk_data_in = (state_q == PUSH_RES) ? result_q : opnd_q;
  assign result          = result_q;
  assign result_valid    = rv_q;
  assign error           = (state_q == ERR);

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Bench for rpn_stack_ctrl with a behavioural 8x4 LIFO attached: fixed
// vectors, corner-case sequences and random tokens against a queue model.
module tb_rpn_stack_ctrl;
  import rpn_pkg::*;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [3:0] result;
  logic       result_valid;
  logic       error;

  rpn_stack_ctrl_if #(.WIDTH(4)) bus ();

  rpn_stack_ctrl #(.WIDTH(4), .DEPTH(8), .DEPTH_W(4)) dut (
    .clk          (clk),
    .rstN         (rstN),
    .bus          (bus),
    .result       (result),
    .result_valid (result_valid),
    .error        (error)
  );

  always #5 clk = ~clk;

  // stack: registered data_out valid the cycle after a pop
  logic [3:0] mem [8];
  logic [3:0] sp;
  logic [3:0] dout;
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sp   <= 4'd0;
      dout <= 4'd0;
    end else if (bus.stk_push && sp < 4'd8) begin
      mem[sp[2:0]] <= bus.stk_data_in;
      sp           <= sp + 4'd1;
    end else if (bus.stk_pop && sp > 4'd0) begin
      dout <= mem[3'(sp - 4'd1)];
      sp   <= sp - 4'd1;
    end
  end
  assign bus.stk_data_out = dout;
  assign bus.stk_full     = (sp == 4'd8);
  assign bus.stk_empty    = (sp == 4'd0);

  int cyc = 0, push_cnt = 0, pop_cnt = 0, rv_cnt = 0, both_cnt = 0;
  int last_push_cyc = 0, last_rv_cyc = 0;
  logic [3:0] last_push_val = 4'd0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.stk_push) begin
      push_cnt      <= push_cnt + 1;
      last_push_cyc <= cyc;
      last_push_val <= bus.stk_data_in;
    end
    if (bus.stk_pop) pop_cnt <= pop_cnt + 1;
    if (bus.stk_push && bus.stk_pop) both_cnt <= both_cnt + 1;
    if (result_valid) begin
      rv_cnt      <= rv_cnt + 1;
      last_rv_cyc <= cyc;
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstN = 1'b0;
    #1;
    chk("rst_tok_ready", int'(bus.tok_ready), 0);
    chk("rst_push", int'(bus.stk_push), 0);
    chk("rst_pop", int'(bus.stk_pop), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_result", int'(result), 0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", int'(bus.tok_ready), 1);
  endtask

  task automatic send_token(input bit is_op, input logic [3:0] data, output int acc);
    int n;
    n = 0;
    acc = -100;
    @(negedge clk);
    while (!bus.tok_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tok_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL tok_ready_timeout: tok_ready=0, expected 1");
      return;
    end
    bus.tok_valid = 1'b1;
    bus.tok_is_op = is_op;
    bus.tok_data  = data;
    @(posedge clk);
    acc = cyc;
    #1;
    bus.tok_valid = 1'b0;
  endtask

  task automatic settle();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.tok_ready && !error && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tok_ready && !error) begin
      n_tests++;
      n_fail++;
      $display("FAIL settle_timeout: controller still busy after 20 cycles");
    end
  endtask

  typedef struct {
    bit         is_op;
    logic [3:0] data;
    logic [3:0] exp_res;
    int         exp_depth;
  } vec_t;

  vec_t vt [17];

  initial begin
    int acc, p0, r0, q0;
    int q[$];
    bit is_op, exp_err;
    logic [3:0] d;
    int a, b, r, exp_res;

    bus.tok_valid = 1'b0;
    bus.tok_is_op = 1'b0;
    bus.tok_data  = 4'd0;
    exp_res = 0;

    vt = '{
      '{1'b0, 4'd3,         4'd0,  1}, '{1'b0, 4'd4,         4'd0,  2},
      '{1'b1, 4'(OP_ADD),   4'd7,  1}, '{1'b0, 4'd2,         4'd7,  2},
      '{1'b0, 4'd5,         4'd7,  3}, '{1'b1, 4'(OP_SUB),   4'd13, 2},
      '{1'b0, 4'd9,         4'd13, 3}, '{1'b0, 4'd9,         4'd13, 4},
      '{1'b1, 4'(OP_ADD),   4'd2,  3}, '{1'b1, 4'(OP_AND),   4'd0,  2},
      '{1'b1, 4'(OP_OR),    4'd7,  1}, '{1'b0, 4'd6,         4'd7,  2},
      '{1'b1, 4'(OP_XOR),   4'd1,  1}, '{1'b0, 4'd15,        4'd1,  2},
      '{1'b1, 4'(OP_ADD),   4'd0,  1}, '{1'b0, 4'd3,         4'd0,  2},
      '{1'b1, 4'(OP_SUB),   4'd13, 1}
    };

    do_reset();

    for (int i = 0; i < 17; i++) begin
      p0 = push_cnt;
      r0 = rv_cnt;
      send_token(vt[i].is_op, vt[i].data, acc);
      settle();
      chk($sformatf("vec%0d_result", i), int'(result), int'(vt[i].exp_res));
      chk($sformatf("vec%0d_depth", i), int'(sp), vt[i].exp_depth);
      chk($sformatf("vec%0d_error", i), int'(error), 0);
      chk($sformatf("vec%0d_pushes", i), push_cnt - p0, 1);
      chk($sformatf("vec%0d_top", i), int'(mem[3'(sp - 4'd1)]),
          vt[i].is_op ? int'(vt[i].exp_res) : int'(vt[i].data));
      if (vt[i].is_op) begin
        chk($sformatf("vec%0d_rv_latency", i), last_rv_cyc - acc, 5);
        chk($sformatf("vec%0d_rv_pulses", i), rv_cnt - r0, 1);
      end else begin
        chk($sformatf("vec%0d_push_latency", i), last_push_cyc - acc, 1);
        chk($sformatf("vec%0d_push_val", i), int'(last_push_val), int'(vt[i].data));
      end
    end

    // overflow: the ninth operand errors without a ninth push
    do_reset();
    p0 = push_cnt;
    for (int i = 0; i < 8; i++) begin
      send_token(1'b0, 4'(i), acc);
      settle();
    end
    send_token(1'b0, 4'd8, acc);
    settle();
    chk("ovf_error", int'(error), 1);
    chk("ovf_tok_ready", int'(bus.tok_ready), 0);
    bus.tok_valid = 1'b1;
    bus.tok_is_op = 1'b0;
    repeat (6) @(negedge clk);
    bus.tok_valid = 1'b0;
    chk("ovf_push_count", push_cnt - p0, 8);
    chk("ovf_depth", int'(sp), 8);
    chk("ovf_error_sticky", int'(error), 1);

    // underflow: op with a single operand, no pop issued
    do_reset();
    q0 = pop_cnt;
    send_token(1'b0, 4'd1, acc);
    settle();
    send_token(1'b1, 4'(OP_AND), acc);
    settle();
    repeat (6) @(negedge clk);
    chk("unf_error", int'(error), 1);
    chk("unf_pops", pop_cnt - q0, 0);
    chk("unf_depth", int'(sp), 1);

    // illegal opcode leaves stack intact; reset clears error and depth
    do_reset();
    q0 = pop_cnt;
    send_token(1'b0, 4'd5, acc);
    settle();
    send_token(1'b0, 4'd6, acc);
    settle();
    send_token(1'b1, 4'd7, acc);
    settle();
    repeat (6) @(negedge clk);
    chk("ill_error", int'(error), 1);
    chk("ill_pops", pop_cnt - q0, 0);
    chk("ill_depth", int'(sp), 2);
    chk("ill_mem0", int'(mem[0]), 5);
    chk("ill_mem1", int'(mem[1]), 6);
    do_reset();
    chk("ill_error_cleared", int'(error), 0);
    q0 = pop_cnt;
    send_token(1'b0, 4'd1, acc);
    settle();
    send_token(1'b1, 4'(OP_ADD), acc);
    settle();
    chk("ill_depth_cleared", int'(error), 1);
    chk("ill_depth_cleared_pops", pop_cnt - q0, 0);

    // reset asserted during POP_A
    do_reset();
    send_token(1'b0, 4'd1, acc);
    settle();
    send_token(1'b0, 4'd2, acc);
    settle();
    send_token(1'b1, 4'(OP_ADD), acc);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid_pop_a_strobe", int'(bus.stk_pop), 1);
    p0 = push_cnt;
    rstN = 1'b0;
    #1;
    chk("mid_pop", int'(bus.stk_pop), 0);
    chk("mid_push", int'(bus.stk_push), 0);
    chk("mid_tok_ready", int'(bus.tok_ready), 0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_ready_after", int'(bus.tok_ready), 1);
    repeat (4) @(negedge clk);
    chk("mid_no_push", push_cnt - p0, 0);
    chk("mid_result_valid", int'(result_valid), 0);

    // random tokens against a queue model of the stack
    do_reset();
    for (int t = 0; t < 400; t++) begin
      if (q.size() < 2) is_op = ($urandom_range(0, 9) == 0);
      else if (q.size() >= 7) is_op = ($urandom_range(0, 9) != 0);
      else is_op = 1'($urandom_range(0, 1));
      if (is_op)
        d = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      else
        d = 4'($urandom);

      exp_err = 1'b0;
      if (!is_op) begin
        if (q.size() >= 8) exp_err = 1'b1;
        else q.push_back(int'(d));
      end else if (q.size() < 2 || d > 4'd4) begin
        exp_err = 1'b1;
      end else begin
        b = q.pop_back();
        a = q.pop_back();
        case (d)
          4'd0:    r = a + b;
          4'd1:    r = a - b;
          4'd2:    r = a & b;
          4'd3:    r = a | b;
          default: r = a ^ b;
        endcase
        r = r & 15;
        q.push_back(r);
        exp_res = r;
      end

      send_token(is_op, d, acc);
      settle();
      chk($sformatf("rnd%0d_error", t), int'(error), int'(exp_err));
      if (exp_err) begin
        do_reset();
        q.delete();
        exp_res = 0;
      end else begin
        chk($sformatf("rnd%0d_depth", t), int'(sp), q.size());
        chk($sformatf("rnd%0d_top", t), int'(mem[3'(sp - 4'd1)]), q[q.size() - 1]);
        chk($sformatf("rnd%0d_result", t), int'(result), exp_res);
      end
    end

    chk("push_pop_overlap", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
